// File: rtl/seq_signed_mult32.sv
// Iterative radix-2 shift-add signed multiplier: WIDTH x WIDTH -> 2*WIDTH product.
// Define VAR_LATENCY_EN for early termination once the remaining multiplier bits are zero.
module seq_signed_mult32 #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     mlier,
    input  logic [WIDTH-1:0]     mcand,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   prodt,
    output logic                 valid
);

    // state   | meaning
    // ST_IDLE | waiting for a start rising edge; prodt holds last result
    // ST_BUSY | one shift-add iteration per clock, cnt counts down to terminal 0

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t             state, state_nxt;
    logic               start_d;
    logic               sign, sign_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [WIDTH-1:0]   mcand_mag, mcand_mag_nxt;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [2*WIDTH-1:0] prodt_nxt;
    logic               valid_nxt;

    logic [WIDTH-1:0]   mlier_abs, mcand_abs;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] mag_prod;
    logic [2*WIDTH-1:0] result;
    logic               done;

`ifdef VAR_LATENCY_EN
    logic [WIDTH-1:0]   rem, rem_nxt;
    logic [CW:0]        shamt;
`endif

    assign mlier_abs = mlier[WIDTH-1] ? -mlier : mlier;
    assign mcand_abs = mcand[WIDTH-1] ? -mcand : mcand;

    // Carry out of the add lands in the MSB as the accumulator shifts right.
    assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand_mag : '0)};
    assign acc_step = {sum, acc[WIDTH-1:1]};

`ifdef VAR_LATENCY_EN
    // Once no multiplier bits remain, the outstanding iterations would only shift.
    assign shamt    = {1'b0, cnt} + (CW+1)'(1);
    assign done     = (rem == '0) || (cnt == '0);
    assign mag_prod = (rem == '0) ? (acc >> shamt) : acc_step;
`else
    assign done     = (cnt == '0);
    assign mag_prod = acc_step;
`endif

    assign result = (sign && (mag_prod != '0)) ? -mag_prod : mag_prod;

    always_comb begin
        state_nxt     = state;
        sign_nxt      = sign;
        cnt_nxt       = cnt;
        mcand_mag_nxt = mcand_mag;
        acc_nxt       = acc;
        prodt_nxt     = prodt;
        valid_nxt     = 1'b0;
`ifdef VAR_LATENCY_EN
        rem_nxt       = rem;
`endif
        case (state)
            ST_IDLE: begin
                if (start && !start_d) begin
                    mcand_mag_nxt = mcand_abs;
                    acc_nxt       = {{WIDTH{1'b0}}, mlier_abs};
                    sign_nxt      = mlier[WIDTH-1] ^ mcand[WIDTH-1];
                    cnt_nxt       = CW'(WIDTH-1);
`ifdef VAR_LATENCY_EN
                    rem_nxt       = (mcand_abs == '0) ? '0 : mlier_abs;
`endif
                    state_nxt     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done) begin
                    prodt_nxt = result;
                    valid_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    acc_nxt = acc_step;
                    cnt_nxt = cnt - CW'(1);
`ifdef VAR_LATENCY_EN
                    rem_nxt = rem >> 1;
`endif
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            start_d   <= 1'b0;
            sign      <= 1'b0;
            cnt       <= '0;
            mcand_mag <= '0;
            acc       <= '0;
            prodt     <= '0;
            valid     <= 1'b0;
`ifdef VAR_LATENCY_EN
            rem       <= '0;
`endif
        end else begin
            state     <= state_nxt;
            start_d   <= start;
            sign      <= sign_nxt;
            cnt       <= cnt_nxt;
            mcand_mag <= mcand_mag_nxt;
            acc       <= acc_nxt;
            prodt     <= prodt_nxt;
            valid     <= valid_nxt;
`ifdef VAR_LATENCY_EN
            rem       <= rem_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_seq_signed_mult32.sv
// Randomized self-checking bench for seq_signed_mult32 against a plain signed-arithmetic model.
// Latency expectations follow the VAR_LATENCY_EN build when that macro is defined.
module tb_seq_signed_mult32;

    logic        clock;
    logic        reset_n;
    logic [31:0] mlier;
    logic [31:0] mcand;
    logic        start;
    logic [63:0] prodt;
    logic        valid;

    int n_checks = 0;
    int n_fail   = 0;

    seq_signed_mult32 #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .mlier   (mlier),
        .mcand   (mcand),
        .start   (start),
        .prodt   (prodt),
        .valid   (valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint pa, pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    function automatic int bit_len(input longint v);
        int n = 0;
        while (v != 0) begin
            n++;
            v = v >> 1;
        end
        return n;
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef VAR_LATENCY_EN
        longint ma;
        int     l;
        if (a == 32'd0 || b == 32'd0) return 1;
        ma = longint'($signed(a));
        if (ma < 0) ma = -ma;
        l = bit_len(ma) + 1;
        return (l > 32) ? 32 : l;
`else
        return 32;
`endif
    endfunction

    // Capture happens on the first posedge after start rises; edges are counted from there.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           input int hold_cyc, input int low_cyc, input bit retrig);
        int          n_valid;
        int          lat;
        logic [63:0] got;
        logic [63:0] exp;
        exp = ref_prod(a, b);
        @(negedge clock);
        mlier = a;
        mcand = b;
        start = 1'b1;
        @(posedge clock);
        n_valid = 0;
        lat     = -1;
        got     = '0;
        for (int k = 1; k <= hold_cyc + low_cyc; k++) begin
            @(posedge clock);
            #1;
            if (valid) begin
                n_valid++;
                if (lat < 0) begin
                    lat = k;
                    got = prodt;
                end
            end
            if (retrig) begin
                if (k == 5) start = 1'b0;
                if (k == 6) start = 1'b1;
                if (k == 8) start = 1'b0;
            end else if (k == hold_cyc) begin
                start = 1'b0;
            end
            mlier = $urandom;
            mcand = $urandom;
        end
        chk($sformatf("prod %h*%h", a, b), got, exp);
        chk($sformatf("lat %h*%h", a, b), 64'(lat), 64'(ref_lat(a, b)));
        chk($sformatf("npulse %h*%h", a, b), 64'(n_valid), 64'd1);
        chk($sformatf("hold %h*%h", a, b), prodt, exp);
    endtask

    function automatic logic [31:0] rand_opnd();
        logic [31:0] v;
        v = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) v = -v;
        if ($urandom_range(0, 7) == 0) v = 32'h8000_0000;
        if ($urandom_range(0, 9) == 0) v = 32'd0;
        return v;
    endfunction

    logic [31:0] dir_a [8] = '{32'h7FFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h80000000,
                               32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h80000000};
    logic [31:0] dir_b [8] = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000,
                               32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};

    initial begin
        int n_valid;
        reset_n = 1'b0;
        start   = 1'b0;
        mlier   = '0;
        mcand   = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_prodt", prodt, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // First directed case holds start for 33 cycles; the rest chain back to back.
        do_mult(dir_a[0], dir_b[0], 33, 5, 1'b0);
        for (int i = 1; i < 8; i++)
            do_mult(dir_a[i], dir_b[i], 1, 31, 1'b0);

        for (int i = 0; i < 4; i++)
            do_mult($urandom, $urandom, 33, 5, 1'b0);

        do_mult($urandom, $urandom, 8, 30, 1'b1);

        for (int i = 0; i < 20; i++)
            do_mult(rand_opnd(), rand_opnd(), 1, 31, 1'b0);

        // Abort a multiply at E10 and confirm nothing emerges afterwards.
        @(negedge clock);
        mlier = 32'h1234_5678;
        mcand = 32'h8765_4321;
        start = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(valid), 64'd0);
        chk("midrst_prodt", prodt, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        n_valid = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (valid) n_valid++;
        end
        chk("midrst_nopulse", 64'(n_valid), 64'd0);
        chk("midrst_prodt_hold", prodt, 64'd0);

        do_mult(32'hDEAD_BEEF, 32'h0000_0003, 1, 31, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
